// File: rtl/onewire_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onewire_pkg
// Description : Shared widths and timing constants for the 1-wire subsystem
//               (byte FIFOs and transceiver).
// Revision    : 1.0 - initial release
// ============================================================================
package onewire_pkg;

   // Bits per buffered byte
   localparam int BYTE_W = 8;

   // log2 of the byte FIFO depth (16 entries)
   localparam int FIFO_ADDR_W = 4;

   // 5 ms at the 100 MHz system clock, used by the transceiver
   localparam logic [18:0] TIMER_5_MS = 19'd500000;

endpackage : onewire_pkg
`default_nettype wire

// File: rtl/onewire_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : onewire_fifo_ram
// Description : Simple dual-port RAM, one write port and one registered read
//               port. No reset so it maps onto block or distributed RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module onewire_fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Write port: store the byte at the write address
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read port: registered, holds its value when not enabled. A read and a
   // write to the same address on one edge return the old contents.
   always_ff @(posedge clk_i) begin
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule : onewire_fifo_ram
`default_nettype wire

// File: rtl/onewire_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : onewire_byte_fifo
// Description : Byte FIFO between the 1-wire transceiver and the host. Level,
//               full/almost-full/empty flags and sticky overflow/underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module onewire_byte_fifo
   import onewire_pkg::*;
#(
   parameter int DATA_WIDTH        = BYTE_W,
   parameter int ADDR_WIDTH        = FIFO_ADDR_W,
   parameter int ALMOST_FULL_LEVEL = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  full_o,
   output logic                  almost_full_o,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic                  empty_o,
   output logic [ADDR_WIDTH:0]   level_o,
   output logic                  overflow_o,
   output logic                  underflow_o,
   input  logic                  clear_errors_i
);

   localparam logic [ADDR_WIDTH:0] C_ONE      = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0] C_DEPTH    = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] C_AF_LEVEL = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);

   logic [ADDR_WIDTH:0]   wr_ptr_q, rd_ptr_q;
   logic [ADDR_WIDTH:0]   level_q, level_d;
   logic                  empty_q, full_q, almost_full_q;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  rd_valid_q;
   logic                  rd_seen_q;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] ram_rd_data;

   // A write into a full FIFO is still taken when the head leaves on the same edge
   assign wr_acc = wr_en_i & (~full_q | rd_en_i);
   assign rd_acc = rd_en_i & ~empty_q;

   onewire_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data_i (wr_data_i),
      .rd_en_i   (rd_acc),
      .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd_data_o (ram_rd_data)
   );

   // Next occupancy and next error-flag state; a new error beats a clear
   always_comb begin
      level_d = level_q;
      if (wr_acc && !rd_acc) begin
         level_d = level_q + C_ONE;
      end else if (rd_acc && !wr_acc) begin
         level_d = level_q - C_ONE;
      end

      overflow_d = overflow_q;
      if (clear_errors_i) begin
         overflow_d = 1'b0;
      end
      if (wr_en_i && full_q && !rd_en_i) begin
         overflow_d = 1'b1;
      end

      underflow_d = underflow_q;
      if (clear_errors_i) begin
         underflow_d = 1'b0;
      end
      if (rd_en_i && empty_q) begin
         underflow_d = 1'b1;
      end
   end

   // Pointers, level, registered flags (from next level) and read strobe
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         empty_q       <= 1'b1;
         full_q        <= 1'b0;
         almost_full_q <= 1'b0;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
         rd_valid_q    <= 1'b0;
         rd_seen_q     <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_q <= wr_ptr_q + C_ONE;
         end
         if (rd_acc) begin
            rd_ptr_q  <= rd_ptr_q + C_ONE;
            rd_seen_q <= 1'b1;
         end
         level_q       <= level_d;
         empty_q       <= (level_d == '0);
         full_q        <= (level_d == C_DEPTH);
         almost_full_q <= (level_d >= C_AF_LEVEL);
         overflow_q    <= overflow_d;
         underflow_q   <= underflow_d;
         rd_valid_q    <= rd_acc;
      end
   end

   // The RAM read register has no reset; until the first read after reset
   // the output is forced to zero by a reset-cleared register.
   assign rd_data_o     = rd_seen_q ? ram_rd_data : '0;
   assign rd_valid_o    = rd_valid_q;
   assign level_o       = level_q;
   assign empty_o       = empty_q;
   assign full_o        = full_q;
   assign almost_full_o = almost_full_q;
   assign overflow_o    = overflow_q;
   assign underflow_o   = underflow_q;

endmodule : onewire_byte_fifo
`default_nettype wire

// File: tb/tb_onewire_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_onewire_byte_fifo
// Description : Self-checking bench for onewire_byte_fifo. A queue-based
//               reference model predicts flags and read data; a monitor
//               compares DUT outputs on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onewire_byte_fifo;

   localparam int DEPTH = 16;
   localparam int AF    = 12;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       rd_en = 1'b0;
   logic       clear_errors = 1'b0;
   logic       full, almost_full, rd_valid, empty, overflow, underflow;
   logic [7:0] rd_data;
   logic [4:0] level;

   int checks = 0;
   int failures = 0;

   // Reference model state: FIFO contents, sticky errors, pending read strobe
   logic [7:0] model_q[$];
   logic [7:0] exp_q[$];
   bit         exp_ovf = 0;
   bit         exp_unf = 0;
   bit         exp_valid = 0;

   onewire_byte_fifo dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .wr_en_i        (wr_en),
      .wr_data_i      (wr_data),
      .full_o         (full),
      .almost_full_o  (almost_full),
      .rd_en_i        (rd_en),
      .rd_data_o      (rd_data),
      .rd_valid_o     (rd_valid),
      .empty_o        (empty),
      .level_o        (level),
      .overflow_o     (overflow),
      .underflow_o    (underflow),
      .clear_errors_i (clear_errors)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One stimulus cycle: drive inputs between edges and advance the model
   task automatic cycle(input bit wr, input bit rd, input logic [7:0] d, input bit clr);
      bit m_full, m_empty, wacc, racc;
      @(negedge clk);
      #1;
      wr_en        = wr;
      rd_en        = rd;
      wr_data      = d;
      clear_errors = clr;
      m_full  = (model_q.size() == DEPTH);
      m_empty = (model_q.size() == 0);
      wacc = wr && (!m_full || rd);
      racc = rd && !m_empty;
      if (racc) exp_q.push_back(model_q.pop_front());
      if (wacc) model_q.push_back(d);
      if (wr && m_full && !rd) exp_ovf = 1;
      else if (clr)            exp_ovf = 0;
      if (rd && m_empty)       exp_unf = 1;
      else if (clr)            exp_unf = 0;
      exp_valid = racc;
   endtask

   // Assert reset between edges and check outputs right away
   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n        = 1'b0;
      wr_en        = 1'b0;
      rd_en        = 1'b0;
      clear_errors = 1'b0;
      model_q.delete();
      exp_q.delete();
      exp_ovf   = 0;
      exp_unf   = 0;
      exp_valid = 0;
      #1;
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_almost_full", int'(almost_full), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_underflow", int'(underflow), 0);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: flags against the model, read data against the scoreboard
   initial begin : monitor
      logic [7:0] last_data;
      logic [7:0] e;
      int sz;
      last_data = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            last_data = 8'h00;
         end else begin
            sz = model_q.size();
            chk("level", int'(level), sz);
            chk("empty", int'(empty), int'(sz == 0));
            chk("full", int'(full), int'(sz == DEPTH));
            chk("almost_full", int'(almost_full), int'(sz >= AF));
            chk("overflow", int'(overflow), int'(exp_ovf));
            chk("underflow", int'(underflow), int'(exp_unf));
            chk("rd_valid", int'(rd_valid), int'(exp_valid));
            if (rd_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  chk("rd_spurious", int'(rd_data), -1);
               end else begin
                  e = exp_q.pop_front();
                  chk("rd_data", int'(rd_data), int'(e));
                  last_data = e;
               end
            end else begin
               chk("rd_data_hold", int'(rd_data), int'(last_data));
            end
         end
      end
   end

   initial begin : stimulus
      int wr_pct, rd_pct;
      do_reset();

      // Two bytes in, two out
      cycle(1, 0, 8'hA5, 0);
      cycle(1, 0, 8'h3C, 0);
      cycle(0, 1, 8'h00, 0);
      cycle(0, 1, 8'h00, 0);
      repeat (2) cycle(0, 0, 8'h00, 0);

      // Fill, overflow attempt, drain
      for (int i = 0; i < 16; i++) cycle(1, 0, 8'(i), 0);
      cycle(1, 0, 8'hFF, 0);
      cycle(0, 0, 8'h00, 0);
      for (int i = 0; i < 16; i++) cycle(0, 1, 8'h00, 0);
      cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 0);

      // Simultaneous read/write while full
      for (int i = 0; i < 16; i++) cycle(1, 0, 8'(i), 0);
      cycle(1, 1, 8'h55, 0);
      for (int i = 0; i < 16; i++) cycle(0, 1, 8'h00, 0);
      cycle(0, 0, 8'h00, 0);

      // Underflow, then simultaneous read/write while empty, then clear
      cycle(0, 1, 8'h00, 0);
      cycle(0, 0, 8'h00, 0);
      cycle(1, 1, 8'h77, 0);
      cycle(0, 1, 8'h00, 1);
      cycle(0, 0, 8'h00, 0);

      // Pointer wrap with write/read pairs
      for (int i = 0; i < 40; i++) begin
         cycle(1, 0, 8'(8'h80 + i), 0);
         cycle(0, 1, 8'h00, 0);
      end
      cycle(0, 0, 8'h00, 0);

      // Clear coinciding with a new error: set wins
      cycle(0, 1, 8'h00, 1);
      cycle(0, 0, 8'h00, 0);

      // Reset mid-transfer at level 5
      for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'hC0 + i), 0);
      cycle(0, 0, 8'h00, 0);
      do_reset();
      cycle(0, 0, 8'h00, 0);

      // Randomised traffic in phases biased toward full, empty and balanced
      for (int p = 0; p < 12; p++) begin
         case (p % 3)
            0:       begin wr_pct = 85; rd_pct = 25; end
            1:       begin wr_pct = 25; rd_pct = 85; end
            default: begin wr_pct = 60; rd_pct = 60; end
         endcase
         for (int c = 0; c < 150; c++) begin
            cycle(($urandom_range(99) < wr_pct), ($urandom_range(99) < rd_pct),
                  8'($urandom), ($urandom_range(15) == 0));
         end
      end

      repeat (3) cycle(0, 0, 8'h00, 0);
      @(negedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_onewire_byte_fifo
`default_nettype wire
